seg_display_ctrl: RTL
=====================

// Module: seg_display_ctrl
// PURPOSE
//  Owns the 4-digit multiplexed 7-segment display and shares it between two value sources
//  (src0 = processor store data, src1 = debug/host).
//  Round-robin arbitrates update requests and converts each granted 16-bit binary value to
//  BCD with a sequential double-dabble unit. Commits the digits atomically and scans the anodes.
//  Sits between the processor/debug logic and the board display pins.
// PARAMETERS
//  REFRESH_BITS  20  width of free-running scan counter; digit select = cnt[REFRESH_BITS-1 -: 2]
//  BLANK_LZ      1   1 = blank leading zero digits (units digit never blanked); 0 = show all
// PORTS
//  clk_100mhz      in   1   system clock, all logic on rising edge
//  reset           in   1   asynchronous, active-high; clears all state
//  src0_valid      in   1   source 0 has a value to display
//  src0_data       in   16  source 0 value (unsigned binary)
//  src0_ready      out  1   source 0 value accepted this cycle
//  src1_valid      in   1   source 1 has a value to display
//  src1_data       in   16  source 1 value (unsigned binary)
//  src1_ready      out  1   source 1 value accepted this cycle
//  hold            in   1   freeze: no new grants while high; display keeps last committed value
//  busy            out  1   conversion in progress
//  disp_value      out  16  last committed binary value
//  overflow        out  1   committed value > 9999
//  Anode_Activate  out  4   active-low digit enables, thousands digit = bit 3
//  LED_out         out  7   active-low segments {a,b,c,d,e,f,g}
// BEHAVIOUR
//  Reset values: src*_ready=0, busy=0, disp_value=0, overflow=0, scan cnt=0 (Anode_Activate=4'b0111).
//   With BLANK_LZ=1 the display shows "   0".
//  FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
//   IDLE: if !hold and any valid, grant one source. srcN_ready=1 combinationally for that cycle only.
//    Transfer = valid & ready; data is latched and the FSM moves to CONVERT.
//   CONVERT: exactly 16 cycles, one shift per cycle; add-3 to each BCD nibble >=5 before the shift.
//    The BCD result is 20 bits (5 nibbles).
//   COMMIT: 1 cycle. Load the 4 digit registers, disp_value, overflow; return to IDLE.
//  Latency: accept in cycle N; busy=1 in cycles N+1..N+17; new digits visible from N+18.
//   Next grant possible at N+18.
//  Arbitration: round-robin on last_grant (reset=1, so src0 wins the first tie).
//   Single requester is always granted. After a grant, last_grant = granted index.
//  ready never asserts outside IDLE or while hold=1.
//   A valid held during CONVERT stays pending and is not dropped.
//   A valid dropped before its grant is simply never serviced.
//  hold rising during CONVERT: the current conversion still commits; only later grants are blocked.
//  Overflow (value >= 10000): all four digits show dash 7'b1111110. Blanking does not apply.
//  Blanking: a digit is blank (7'b1111111) if BLANK_LZ and it and all more-significant digits are 0.
//   The units digit is never blank.
//  Scan: sel 00/01/10/11 -> anode 0111/1011/1101/1110 -> thousands/hundreds/tens/units.
//   Scan runs continuously, independent of FSM state and hold.
//  Reset mid-CONVERT: conversion aborted, nothing committed, all registers return to reset values.
// STRUCTURE
//  Package seg_disp_pkg: segment patterns for 0-9, SEG_BLANK, SEG_DASH, anode patterns,
//   FSM state enum, MAX_DISP=9999.
//  Sub-module bin2bcd_seq: 16-bit sequential double-dabble with start/done, 20-bit BCD out, 16-cycle run.
//  Top level holds the arbiter, FSM, digit registers, blanking/overflow mux and scan counter.
// TESTING
//  Reset, no requests: Anode cycles 0111->1011->1101->1110 every 2^18 clks;
//   LED_out = blank,blank,blank,0000001.
//  src0 value 6765: src0_ready 1 cycle; busy 17 cycles; disp_value=6765; digits 6,7,6,5
//   (0100000,0001111,0100000,0100100).
//  src0 and src1 both valid with 1234 and 42: src0 first, then src1.
//   Final disp_value=42, display "  42". Each ready pulses exactly once.
//  src1 value 10000: overflow=1, all four digits 1111110. A following value of 9999 clears overflow.
//  hold=1 with src0 valid: src0_ready stays 0 and disp_value is unchanged.
//   Release hold: grant occurs the next cycle.
//  Reset pulse at cycle 8 of CONVERT: busy=0, disp_value=0, no commit.
//   The pending request is re-granted after reset deasserts.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 7-segment display controller.
//   - FSM state enum for the arbitration/convert/commit sequence
//   - Active-low segment patterns {a,b,c,d,e,f,g} for 0-9, blank and dash
//   - Active-low anode patterns, thousands digit on bit 3
//   - MAX_DISP: largest value that fits on four decimal digits
package seg_disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  localparam logic [15:0] MAX_DISP = 16'd9999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [3:0] AN_THOUSANDS = 4'b0111;
  localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
  localparam logic [3:0] AN_TENS      = 4'b1101;
  localparam logic [3:0] AN_UNITS     = 4'b1110;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 20-bit BCD converter (double dabble).
//   clk_100mhz  in   clock, rising edge
//   reset       in   asynchronous active-high reset, aborts a running conversion
//   start       in   load bin and begin a 16-cycle conversion
//   bin         in   16-bit unsigned value, sampled when start is high
//   done        out  high during the cycle whose clock edge performs the final shift;
//                    bcd holds the complete result from the following cycle on
//   bcd         out  5 BCD nibbles, most significant nibble in [19:16]
module bin2bcd_seq (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] shreg;
  logic [3:0]  step;
  logic        running;
  logic [19:0] adj;

  // Add 3 to every nibble >= 5 ahead of the shift.
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bcd     <= '0;
      step    <= '0;
      running <= 1'b0;
    end else if (start) begin
      shreg   <= bin;
      bcd     <= '0;
      step    <= '0;
      running <= 1'b1;
    end else if (running) begin
      {bcd, shreg} <= {adj[18:0], shreg, 1'b0};
      step         <= step + 4'd1;
      if (step == 4'd15) running <= 1'b0;
    end
  end

  assign done = running && (step == 4'd15);

endmodule

// File: rtl/seg_display_ctrl.sv
// 4-digit multiplexed 7-segment display controller shared by two sources.
//   clk_100mhz      in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   src0_valid/data in   processor store value request (16-bit unsigned)
//   src0_ready      out  src0 value accepted this cycle
//   src1_valid/data in   debug/host value request (16-bit unsigned)
//   src1_ready      out  src1 value accepted this cycle
//   hold            in   block new grants; display keeps last committed value
//   busy            out  conversion/commit in progress
//   disp_value      out  last committed binary value
//   overflow        out  committed value > 9999 (all digits show a dash)
//   Anode_Activate  out  active-low digit enables, thousands on bit 3
//   LED_out         out  active-low segments {a,b,c,d,e,f,g}
// A granted value is converted to BCD over 16 cycles and the four digits,
// disp_value and overflow are committed together in a single cycle.
module seg_display_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 20,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        src0_valid,
  input  logic [15:0] src0_data,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [15:0] src1_data,
  output logic        src1_ready,
  input  logic        hold,
  output logic        busy,
  output logic [15:0] disp_value,
  output logic        overflow,
  output logic [3:0]  Anode_Activate,
  output logic [6:0]  LED_out
);

  state_t                  state;
  logic                    last_grant;
  logic                    grant0, grant1, take;
  logic [15:0]             sel_data, value_q;
  logic                    conv_done;
  logic [19:0]             bcd;
  logic                    unused_bcd_hi;
  logic [3:0][3:0]         digits;
  logic [3:0]              dig_zero, blank_lz;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              sel, idx;

  // Round-robin: on a tie the source not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE && !hold && !reset) begin
      if (src0_valid && src1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = src0_valid;
        grant1 = src1_valid;
      end
    end
  end

  assign src0_ready = grant0;
  assign src1_ready = grant1;
  assign take       = grant0 | grant1;
  assign sel_data   = grant1 ? src1_data : src0_data;
  assign busy       = (state != S_IDLE);

  bin2bcd_seq u_bin2bcd (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .start      (take),
    .bin        (sel_data),
    .done       (conv_done),
    .bcd        (bcd)
  );

  // Ten-thousands nibble is implied by overflow, which is taken from the binary value.
  assign unused_bcd_hi = |bcd[19:16];

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      value_q    <= '0;
      disp_value <= '0;
      overflow   <= 1'b0;
      digits     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            value_q    <= sel_data;
            last_grant <= grant1;
            state      <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (conv_done) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp_value <= value_q;
          overflow   <= (value_q > MAX_DISP);
          digits     <= bcd[15:0];
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + REFRESH_BITS'(1);
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];
  // sel 0 scans the thousands digit, which lives at digits[3].
  assign idx = ~sel;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) dig_zero[i] = (digits[i] == 4'd0);
  end

  // A digit blanks only when it and every more-significant digit are zero.
  assign blank_lz = {BLANK_LZ & dig_zero[3],
                     BLANK_LZ & (&dig_zero[3:2]),
                     BLANK_LZ & (&dig_zero[3:1]),
                     1'b0};

  always_comb begin
    case (sel)
      2'd0:    Anode_Activate = AN_THOUSANDS;
      2'd1:    Anode_Activate = AN_HUNDREDS;
      2'd2:    Anode_Activate = AN_TENS;
      default: Anode_Activate = AN_UNITS;
    endcase
    if (overflow)           LED_out = SEG_DASH;
    else if (blank_lz[idx]) LED_out = SEG_BLANK;
    else                    LED_out = seg_of_digit(digits[idx]);
  end

endmodule
